// File: rtl/beam_pattern_gen.sv
// Beam-input pattern transmitter: bursts of {pre-gap, pulse, post-gap} frames with a qualified-frame flag.
// Optional single-cycle post-gap glitch injection enabled by defining BEAM_GEN_GLITCH_EN.
module beam_pattern_gen #(
  parameter int CNT_W    = 8,
  parameter int BURST_W  = 8,
  parameter int MIN_PRE  = 12,
  parameter int MIN_POST = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   pre_gap,
  input  logic [CNT_W-1:0]   pulse_len,
  input  logic [CNT_W-1:0]   post_gap,
  input  logic [BURST_W-1:0] burst_cnt,
  input  logic [CNT_W-1:0]   glitch_at,
  output logic               o_beam,
  output logic               busy,
  output logic               done,
  output logic               expect_trig,
  output logic [BURST_W-1:0] frame_idx
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_PULSE, S_POST, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   pre_q, pre_d, pulse_q, pulse_d, post_q, post_d;
  logic [BURST_W-1:0] burst_q, burst_d, frame_idx_q, frame_idx_d;
  logic               o_beam_q, o_beam_d, busy_q, busy_d, done_q, done_d;
  logic               trig_q, trig_d;
  logic               frame_end, qual_d, glitch_hi;

`ifdef BEAM_GEN_GLITCH_EN
  logic [CNT_W-1:0]   glitch_q, glitch_d;
  logic               glitch_hit_d;
`else
  logic               unused_glitch;
  assign unused_glitch = ^glitch_at;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    pulse_d     = pulse_q;
    post_d      = post_q;
    burst_d     = burst_q;
    frame_idx_d = frame_idx_q;
    frame_end   = 1'b0;
    glitch_hi   = 1'b0;
`ifdef BEAM_GEN_GLITCH_EN
    glitch_d    = glitch_q;
`endif

    case (state_q)
      S_IDLE: if (start) begin
        pre_d       = pre_gap;
        pulse_d     = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
        post_d      = post_gap;
        burst_d     = (burst_cnt == '0) ? BURST_W'(1) : burst_cnt;
`ifdef BEAM_GEN_GLITCH_EN
        glitch_d    = glitch_at;
`endif
        cnt_d       = '0;
        frame_idx_d = '0;
        state_d     = (pre_gap == '0) ? S_PULSE : S_PRE;
      end
      S_PRE: begin
        if (cnt_q == pre_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == pulse_q - CNT_W'(1)) begin
          cnt_d = '0;
          if (post_q == '0) frame_end = 1'b1;
          else              state_d   = S_POST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_POST: begin
`ifdef BEAM_GEN_GLITCH_EN
        glitch_hi = (glitch_q != '0) && (cnt_q == glitch_q);
`endif
        if (cnt_q == post_q - CNT_W'(1)) begin
          cnt_d     = '0;
          frame_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        frame_idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Widened compare so burst_cnt = 2^BURST_W-1 still terminates cleanly.
    if (frame_end) begin
      if (({1'b0, frame_idx_q} + (BURST_W+1)'(1)) < {1'b0, burst_q}) begin
        frame_idx_d = frame_idx_q + BURST_W'(1);
        state_d     = (pre_q == '0) ? S_PULSE : S_PRE;
      end else begin
        state_d = S_DONE;
      end
    end

    qual_d = (pre_d >= CNT_W'(MIN_PRE)) && (post_d >= CNT_W'(MIN_POST));
`ifdef BEAM_GEN_GLITCH_EN
    glitch_hit_d = (glitch_d != '0) && (glitch_d < post_d);
    qual_d       = qual_d && !glitch_hit_d;
`endif

    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      frame_idx_d = '0;
    end

    busy_d = (state_d == S_PRE) || (state_d == S_PULSE) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
    // Flag lands on the final cycle of the frame, which is the last PULSE cycle when post-gap is empty.
    trig_d = qual_d &&
             (((state_d == S_POST) && (cnt_d == post_d - CNT_W'(1))) ||
              ((state_d == S_PULSE) && (post_d == '0) && (cnt_d == pulse_d - CNT_W'(1))));
    o_beam_d = !abort && ((state_q == S_PULSE) || glitch_hi);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      pulse_q     <= '0;
      post_q      <= '0;
      burst_q     <= '0;
      frame_idx_q <= '0;
      o_beam_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
`ifdef BEAM_GEN_GLITCH_EN
      glitch_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      pulse_q     <= pulse_d;
      post_q      <= post_d;
      burst_q     <= burst_d;
      frame_idx_q <= frame_idx_d;
      o_beam_q    <= o_beam_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_q      <= trig_d;
`ifdef BEAM_GEN_GLITCH_EN
      glitch_q    <= glitch_d;
`endif
    end
  end

  assign o_beam      = o_beam_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign expect_trig = trig_q;
  assign frame_idx   = frame_idx_q;

endmodule

// File: tb/tb_beam_pattern_gen.sv
// Self-checking bench for beam_pattern_gen: per-cycle timeline model built from burst configuration.
// Honours BEAM_GEN_GLITCH_EN in the reference model when the design is built with it.
module tb_beam_pattern_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pre_gap = '0, pulse_len = '0, post_gap = '0, burst_cnt = '0, glitch_at = '0;
  logic       o_beam, busy, done, expect_trig;
  logic [7:0] frame_idx;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       hi;    // this cycle drives the beam high one clock later
    logic       busy;
    logic       done;
    logic       trig;
    logic [7:0] idx;
  } cyc_t;

  beam_pattern_gen #(.CNT_W(8), .BURST_W(8), .MIN_PRE(12), .MIN_POST(12)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .pre_gap(pre_gap), .pulse_len(pulse_len), .post_gap(post_gap),
    .burst_cnt(burst_cnt), .glitch_at(glitch_at),
    .o_beam(o_beam), .busy(busy), .done(done), .expect_trig(expect_trig),
    .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] observed();
    return {o_beam, busy, done, expect_trig, frame_idx};
  endfunction

  task automatic check_idle(input string name, input int k);
    @(negedge clk);
    tests++;
    if (observed() !== 12'h000) begin
      fails++;
      $display("FAIL %s idle k=%0d got=%h exp=%h", name, k, observed(), 12'h000);
    end
  endtask

  // Runs one burst from IDLE; stop_at >= 0 aborts (or resets) after checking that cycle.
  task automatic run_burst(input string name, input int pre, input int pulse, input int post,
                           input int burst, input int glitch, input int stop_at,
                           input bit by_reset, input bit scramble);
    cyc_t q[$];
    cyc_t c;
    int   pl = (pulse == 0) ? 1 : pulse;
    int   nb = (burst == 0) ? 1 : burst;
    bit   ghit = 1'b0;
    bit   qual;
    logic exp_beam;
    logic [11:0] expv;
`ifdef BEAM_GEN_GLITCH_EN
    ghit = (glitch != 0) && (glitch < post);
`endif
    qual = (pre >= 12) && (post >= 12) && !ghit;
    for (int f = 0; f < nb; f++) begin
      for (int i = 0; i < pre; i++)  q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'(f)});
      for (int i = 0; i < pl; i++)   q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'(f)});
      for (int i = 0; i < post; i++) q.push_back('{ghit && (i == glitch), 1'b1, 1'b0, 1'b0, 8'(f)});
      c = q[q.size()-1];
      c.trig = qual;
      q[q.size()-1] = c;
    end
    q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'(nb-1)});
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00});

    @(negedge clk);
    pre_gap = 8'(pre); pulse_len = 8'(pulse); post_gap = 8'(post);
    burst_cnt = 8'(burst); glitch_at = 8'(glitch);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      exp_beam = (k == 0) ? 1'b0 : q[k-1].hi;
      expv = {exp_beam, q[k].busy, q[k].done, q[k].trig, q[k].idx};
      tests++;
      if (observed() !== expv) begin
        fails++;
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, observed(), expv);
      end
      if (k == stop_at && k < q.size() - 1) begin
        if (by_reset) reset_n = 1'b0;
        else          abort   = 1'b1;
        start = $urandom_range(0, 1) == 1;
        @(negedge clk);
        tests++;
        if (observed() !== 12'h000) begin
          fails++;
          $display("FAIL %s stop k=%0d got=%h exp=%h", name, k, observed(), 12'h000);
        end
        reset_n = 1'b1; abort = 1'b0; start = 1'b0;
        check_idle(name, k + 1);
        check_idle(name, k + 2);
        return;
      end
      start = (k < q.size() - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (scramble) begin
        pre_gap = 8'($urandom); pulse_len = 8'($urandom); post_gap = 8'($urandom);
        burst_cnt = 8'($urandom); glitch_at = 8'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (observed() !== 12'h000) begin
      fails++;
      $display("FAIL reset got=%h exp=%h", observed(), 12'h000);
    end
    reset_n = 1'b1;
    check_idle("reset_release", 0);
  endtask

  task automatic test_single_frame();
    run_burst("t1_single", 12, 3, 12, 1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_multi_frame();
    run_burst("t2_multi", 5, 3, 20, 3, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_zero_config();
    run_burst("t3_zero", 0, 0, 0, 0, 0, -1, 1'b0, 1'b1);
    run_burst("zero_pre_multi", 0, 2, 12, 2, 0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    // frame 2 (index 1) PULSE of pre=4 pulse=3 post=4: frame length 11, so cycle 11+4+1
    run_burst("t4_abort", 4, 3, 4, 4, 0, 16, 1'b0, 1'b1);
    run_burst("t4_reset_pre", 14, 3, 12, 2, 0, 5, 1'b1, 1'b1);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    pre_gap = 8'd3; pulse_len = 8'd2; post_gap = 8'd3; burst_cnt = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tests++;
    if (observed() !== 12'h000) begin
      fails++;
      $display("FAIL abort_start got=%h exp=%h", observed(), 12'h000);
    end
    check_idle("abort_start", 1);
  endtask

  task automatic test_max_count();
    run_burst("max_count", 255, 255, 255, 1, 0, -1, 1'b0, 1'b1);
  endtask

  task automatic test_glitch();
    run_burst("t6_glitch", 12, 2, 12, 1, 4, -1, 1'b0, 1'b1);
    run_burst("glitch_oob", 12, 1, 12, 2, 12, -1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 30; n++) begin
      int stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 60)) : -1;
      run_burst("random", $urandom_range(0, 16), $urandom_range(0, 4), $urandom_range(0, 16),
                $urandom_range(0, 3), $urandom_range(0, 8), stop, $urandom_range(0, 1) == 1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_zero_config();
    test_abort();
    test_abort_start_idle();
    test_max_count();
    test_glitch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
